// File: rtl/gru_step_sequencer.sv
// One GRU recurrence step per accepted sample, with five micro-ops time-shared
// onto an external multiply-accumulate + activation unit. Holds h and gate weights.
//
// state  | meaning
// IDLE   | accept a sample or a config write
// ISSUE  | present op k to the shared unit for one cycle
// WAIT   | wait for the unit result of op k
// OUTPUT | present the new h until the consumer takes it
module gru_step_sequencer #(
    parameter int DATA_WIDTH  = 8,
    parameter int FRACT_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_we,
    input  logic [3:0]            cfg_addr,
    input  logic [DATA_WIDTH-1:0] cfg_data,
    output logic                  cfg_err,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_x,
    input  logic                  in_first,
    output logic                  op_valid,
    output logic [DATA_WIDTH-1:0] op_a,
    output logic [DATA_WIDTH-1:0] op_wa,
    output logic [DATA_WIDTH-1:0] op_b,
    output logic [DATA_WIDTH-1:0] op_wb,
    output logic [DATA_WIDTH-1:0] op_bias,
    output logic [1:0]            op_act,
    input  logic                  res_valid,
    input  logic [DATA_WIDTH-1:0] res_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_h,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT   = 2'd2,
        S_OUTPUT = 2'd3
    } state_t;

    localparam logic [1:0] ACT_NONE = 2'd0;
    localparam logic [1:0] ACT_SIG  = 2'd1;
    localparam logic [1:0] ACT_TANH = 2'd2;
    localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1) << FRACT_WIDTH;

    state_t state_q, state_d;
    logic [2:0] k_q, k_d;

    logic [DATA_WIDTH-1:0] wz_q, wr_q, wh_q, uz_q, ur_q, uh_q, bz_q, br_q, bh_q;
    logic [DATA_WIDTH-1:0] x_q, h_q, zt_q, rt_q, ht0_q, ht_q;
    logic [DATA_WIDTH-1:0] op_a_q, op_wa_q, op_b_q, op_wb_q, op_bias_q;
    logic [1:0]            op_act_q;
    logic                  cfg_err_q;

    logic [DATA_WIDTH-1:0] mux_a, mux_wa, mux_b, mux_wb, mux_bias, om;
    logic [1:0]            mux_act;

    // Wrap-around on purpose: the shared unit sees the raw two's-complement difference.
    assign om = ONE - zt_q;

    always_comb begin
        mux_a    = '0;
        mux_wa   = '0;
        mux_b    = '0;
        mux_wb   = '0;
        mux_bias = '0;
        mux_act  = ACT_NONE;
        case (k_q)
            3'd0: begin
                mux_a = x_q;  mux_wa = wz_q; mux_b = h_q; mux_wb = uz_q;
                mux_bias = bz_q; mux_act = ACT_SIG;
            end
            3'd1: begin
                mux_a = x_q;  mux_wa = wr_q; mux_b = h_q; mux_wb = ur_q;
                mux_bias = br_q; mux_act = ACT_SIG;
            end
            3'd2: begin
                mux_a = rt_q; mux_wa = h_q;  mux_bias = bh_q;
            end
            3'd3: begin
                mux_a = x_q;  mux_wa = wh_q; mux_b = ht0_q; mux_wb = uh_q;
                mux_act = ACT_TANH;
            end
            3'd4: begin
                mux_a = om;   mux_wa = h_q;  mux_b = zt_q; mux_wb = ht_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_ISSUE;
                    k_d     = 3'd0;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (res_valid) begin
                    if (k_q == 3'd4) begin
                        state_d = S_OUTPUT;
                    end else begin
                        k_d     = k_q + 3'd1;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_OUTPUT: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            wz_q <= '0; wr_q <= '0; wh_q <= '0;
            uz_q <= '0; ur_q <= '0; uh_q <= '0;
            bz_q <= '0; br_q <= '0; bh_q <= '0;
            x_q <= '0; h_q <= '0; zt_q <= '0; rt_q <= '0; ht0_q <= '0; ht_q <= '0;
            op_a_q <= '0; op_wa_q <= '0; op_b_q <= '0; op_wb_q <= '0; op_bias_q <= '0;
            op_act_q  <= ACT_NONE;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            cfg_err_q <= cfg_we && ((state_q != S_IDLE) || (cfg_addr >= 4'd9));

            // A write coinciding with sample acceptance lands before the first ISSUE.
            if (cfg_we && state_q == S_IDLE) begin
                case (cfg_addr)
                    4'd0: wz_q <= cfg_data;
                    4'd1: wr_q <= cfg_data;
                    4'd2: wh_q <= cfg_data;
                    4'd3: uz_q <= cfg_data;
                    4'd4: ur_q <= cfg_data;
                    4'd5: uh_q <= cfg_data;
                    4'd6: bz_q <= cfg_data;
                    4'd7: br_q <= cfg_data;
                    4'd8: bh_q <= cfg_data;
                    default: ;
                endcase
            end

            if (state_q == S_IDLE && in_valid) begin
                x_q <= in_x;
                if (in_first) h_q <= '0;
            end

            if (state_q == S_ISSUE) begin
                op_a_q    <= mux_a;
                op_wa_q   <= mux_wa;
                op_b_q    <= mux_b;
                op_wb_q   <= mux_wb;
                op_bias_q <= mux_bias;
                op_act_q  <= mux_act;
            end

            if (state_q == S_WAIT && res_valid) begin
                case (k_q)
                    3'd0: zt_q  <= res_data;
                    3'd1: rt_q  <= res_data;
                    3'd2: ht0_q <= res_data;
                    3'd3: ht_q  <= res_data;
                    3'd4: h_q   <= res_data;
                    default: ;
                endcase
            end
        end
    end

    // Operands come straight from the mux during ISSUE, then hold until the next ISSUE.
    assign op_valid  = (state_q == S_ISSUE);
    assign op_a      = op_valid ? mux_a    : op_a_q;
    assign op_wa     = op_valid ? mux_wa   : op_wa_q;
    assign op_b      = op_valid ? mux_b    : op_b_q;
    assign op_wb     = op_valid ? mux_wb   : op_wb_q;
    assign op_bias   = op_valid ? mux_bias : op_bias_q;
    assign op_act    = op_valid ? mux_act  : op_act_q;

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_OUTPUT);
    assign out_h     = h_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_gru_step_sequencer.sv
// Directed bench for gru_step_sequencer: a fixed-latency unit model returns
// hand-picked results; a scoreboard checks every issued op and every output h.
module tb_gru_step_sequencer;

    localparam int L = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_we;
    logic [3:0] cfg_addr;
    logic [7:0] cfg_data;
    logic       cfg_err;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_x;
    logic       in_first;
    logic       op_valid;
    logic [7:0] op_a, op_wa, op_b, op_wb, op_bias;
    logic [1:0] op_act;
    logic       res_valid;
    logic [7:0] res_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_h;
    logic       busy;

    always #5 clk = ~clk;

    gru_step_sequencer dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_first(in_first),
        .op_valid(op_valid), .op_a(op_a), .op_wa(op_wa), .op_b(op_b), .op_wb(op_wb),
        .op_bias(op_bias), .op_act(op_act),
        .res_valid(res_valid), .res_data(res_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_h(out_h), .busy(busy)
    );

    typedef struct packed {
        logic [7:0] a, wa, b, wb, bias;
        logic [1:0] act;
    } op_t;

    op_t        exp_op_q[$];
    logic [7:0] exp_out_q[$];
    logic [7:0] res_q[$];

    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   out_first_cyc = 0;
    logic out_valid_prev = 1'b0;
    op_t  mon_got;
    int   op_seen;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic push_op(input logic [7:0] a, wa, b, wb, bias, input logic [1:0] act);
        op_t o;
        o.a = a; o.wa = wa; o.b = b; o.wb = wb; o.bias = bias; o.act = act;
        exp_op_q.push_back(o);
    endtask

    // Scoreboard monitor, sampled 1 time unit after the falling edge so it sees settled stimulus.
    always @(negedge clk) begin
        #1;
        if (!rst) begin
            if (op_valid) begin
                mon_got = '{op_a, op_wa, op_b, op_wb, op_bias, op_act};
                if (exp_op_q.size() == 0) chk("unexpected_op", mon_got, 0);
                else chk("op_operands", mon_got, exp_op_q.pop_front());
            end
            if (out_valid && !out_valid_prev) out_first_cyc = cyc;
            if (out_valid && out_ready) begin
                if (exp_out_q.size() == 0) chk("unexpected_out", {56'd0, out_h}, 64'hDEAD);
                else chk("out_h", out_h, exp_out_q.pop_front());
            end
        end
        out_valid_prev = out_valid;
    end

    // Shared-unit model: result appears L cycles after the issue cycle.
    initial begin
        logic [7:0] r;
        res_valid = 1'b0;
        res_data  = '0;
        forever begin
            @(negedge clk);
            if (op_valid) begin
                r = (res_q.size() != 0) ? res_q.pop_front() : 8'h00;
                repeat (L) @(posedge clk);
                #1 res_valid = 1'b1; res_data = r;
                @(posedge clk);
                #1 res_valid = 1'b0;
            end
        end
    end

    task automatic cfg_write(input logic [3:0] a, input logic [7:0] d, input logic exp_err,
                             input string nm);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
        chk(nm, cfg_err, exp_err);
    endtask

    task automatic send(input logic [7:0] x, input logic first);
        int t = 0;
        @(negedge clk);
        in_valid = 1'b1; in_x = x; in_first = first;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("accept_timeout", 0, 1);
        acc_cyc = cyc;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int t = 0;
        while ((busy || exp_out_q.size() != 0 || exp_op_q.size() != 0) && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk(nm, exp_op_q.size() + exp_out_q.size() + (busy ? 1 : 0), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        in_valid = 1'b0; in_x = '0; in_first = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_out", {out_valid, out_h}, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_ops", {op_valid, op_a, op_wa, op_b, op_wb, op_bias, op_act}, 0);
        op_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (op_valid) op_seen++;
        end
        chk("idle_no_op", op_seen, 0);

        // Wz Wr Wh Uz Ur Uh bz br bh
        cfg_write(4'd0, 8'h20, 1'b0, "cfg_ok_wz");
        cfg_write(4'd1, 8'h11, 1'b0, "cfg_ok_wr");
        cfg_write(4'd2, 8'h12, 1'b0, "cfg_ok_wh");
        cfg_write(4'd3, 8'h10, 1'b0, "cfg_ok_uz");
        cfg_write(4'd4, 8'h13, 1'b0, "cfg_ok_ur");
        cfg_write(4'd5, 8'h14, 1'b0, "cfg_ok_uh");
        cfg_write(4'd6, 8'h08, 1'b0, "cfg_ok_bz");
        cfg_write(4'd7, 8'h05, 1'b0, "cfg_ok_br");
        cfg_write(4'd8, 8'h06, 1'b0, "cfg_ok_bh");

        // Step 1: x=0x10, first; results Zt=10 Rt=18 ht0=04 Ht=0C, h=(0x10*0x0C)>>5=0x06
        push_op(8'h10, 8'h20, 8'h00, 8'h10, 8'h08, 2'd1);
        push_op(8'h10, 8'h11, 8'h00, 8'h13, 8'h05, 2'd1);
        push_op(8'h18, 8'h00, 8'h00, 8'h00, 8'h06, 2'd0);
        push_op(8'h10, 8'h12, 8'h04, 8'h14, 8'h00, 2'd2);
        push_op(8'h10, 8'h00, 8'h10, 8'h0C, 8'h00, 2'd0);
        res_q = '{8'h10, 8'h18, 8'h04, 8'h0C, 8'h06};
        exp_out_q.push_back(8'h06);
        send(8'h10, 1'b1);
        t = 0;
        while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("out_valid_timeout", t < 100, 1);

        // Step 2 offered while OUTPUT is stalled: x=0x08, h=0x06 carried over
        push_op(8'h08, 8'h20, 8'h06, 8'h10, 8'h08, 2'd1);
        push_op(8'h08, 8'h11, 8'h06, 8'h13, 8'h05, 2'd1);
        push_op(8'h10, 8'h06, 8'h00, 8'h00, 8'h06, 2'd0);
        push_op(8'h08, 8'h12, 8'h02, 8'h14, 8'h00, 2'd2);
        push_op(8'h18, 8'h06, 8'h08, 8'h04, 8'h00, 2'd0);
        res_q = '{8'h08, 8'h10, 8'h02, 8'h04, 8'h05};
        exp_out_q.push_back(8'h05);
        in_valid = 1'b1; in_x = 8'h08; in_first = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_out", {out_valid, out_h}, {1'b1, 8'h06});
            chk("hold_in_ready", in_ready, 0);
        end
        // Step latency counts the accept cycle as cycle 1: out_valid in cycle 22.
        chk("step_latency", out_first_cyc - acc_cyc + 1, 22);
        out_ready = 1'b1;
        @(negedge clk);
        chk("accept_after_out", {in_ready, out_valid}, 2'b10);
        @(negedge clk);
        in_valid = 1'b0;
        wait_done("step2_done");

        // Step 3: cfg write of bz=0x09 together with acceptance; Zt=0x90 makes om wrap.
        push_op(8'h04, 8'h20, 8'h00, 8'h10, 8'h09, 2'd1);
        push_op(8'h04, 8'h11, 8'h00, 8'h13, 8'h05, 2'd1);
        push_op(8'h01, 8'h00, 8'h00, 8'h00, 8'h06, 2'd0);
        push_op(8'h04, 8'h12, 8'h03, 8'h14, 8'h00, 2'd2);
        push_op(8'h90, 8'h00, 8'h90, 8'h07, 8'h00, 2'd0);
        res_q = '{8'h90, 8'h01, 8'h03, 8'h07, 8'h11};
        exp_out_q.push_back(8'h11);
        @(negedge clk);
        in_valid = 1'b1; in_x = 8'h04; in_first = 1'b1;
        cfg_we = 1'b1; cfg_addr = 4'd6; cfg_data = 8'h09;
        @(negedge clk);
        in_valid = 1'b0; cfg_we = 1'b0;
        chk("cfg_with_accept_err", cfg_err, 0);
        t = 0;
        while (!op_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        chk("in_wait_busy", {busy, op_valid}, 2'b10);
        cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 8'h55;
        @(negedge clk);
        cfg_we = 1'b0;
        chk("cfg_err_busy", cfg_err, 1);
        @(negedge clk);
        chk("cfg_err_one_cycle", cfg_err, 0);
        wait_done("step3_done");

        cfg_write(4'd12, 8'h77, 1'b1, "cfg_err_reserved");

        // Step 4: Wz must still be 0x20, h=0x11; abort with reset during WAIT.
        push_op(8'h02, 8'h20, 8'h11, 8'h10, 8'h09, 2'd1);
        res_q = '{8'h3C};
        send(8'h02, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ctrl", {in_ready, busy, op_valid, out_valid, cfg_err}, 5'b10000);
        chk("abort_ops", {op_a, op_wa, op_b, op_wb, op_bias, op_act}, 0);
        chk("abort_out_h", out_h, 0);
        @(negedge clk);
        chk("stray_res_ignored", {in_ready, busy, out_valid}, 3'b100);
        @(negedge clk);
        chk("stray_res_no_issue", {busy, op_valid}, 2'b00);

        // Step 5: reset cleared weights and h, so k0 is all zero except x.
        push_op(8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 2'd1);
        res_q = '{8'h00};
        send(8'h01, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("queues_drained", exp_op_q.size() + exp_out_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/gru_step_sequencer.md
Name: gru_step_sequencer

Overview:
- Sequences one GRU recurrence step per accepted input sample.
- Time-shares a single external multiply-accumulate + activation unit (ConcatMultAdd-style datapath followed by a sigmoid/tanh LUT) across the five GRU micro-operations.
- Holds the recurrent state h and the gate weight/bias registers.
- Sits between the sample stream source and the shared arithmetic unit; emits the updated h per step.

Parameters:
- DATA_WIDTH, 8, width of all data, weight and bias values (signed, two's complement).
- FRACT_WIDTH, 5, fractional bits; fixed-point 1.0 = 1<<FRACT_WIDTH (0x20 at default).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cfg_we  in  1  weight/bias register write strobe
- cfg_addr  in  4  0..8 select Wz,Wr,Wh,Uz,Ur,Uh,bz,br,bh; 9..15 reserved
- cfg_data  in  DATA_WIDTH  write data
- cfg_err  out  1  one-cycle pulse: write dropped (not IDLE, or reserved address)
- in_valid  in  1  input sample valid
- in_ready  out  1  sequencer can accept a sample
- in_x  in  DATA_WIDTH  input sample X
- in_first  in  1  sampled with in_x; clears h to 0 before this step
- op_valid  out  1  one-cycle issue strobe to shared unit
- op_a, op_wa, op_b, op_wb, op_bias  out  DATA_WIDTH each  operands; unit computes act(((a*wa + b*wb) >> FRACT_WIDTH) + bias)
- op_act  out  2  0 none, 1 sigmoid, 2 tanh, 3 reserved (never driven)
- res_valid  in  1  result strobe from shared unit (any latency >= 1)
- res_data  in  DATA_WIDTH  result
- out_valid  out  1  new h available
- out_ready  in  1  consumer accepts out_h
- out_h  out  DATA_WIDTH  updated recurrent state
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset: state IDLE, all weight/bias registers 0, h 0, Zt/Rt/ht0/Ht/x regs 0.
  - Outputs after reset: in_ready 1, op_valid 0, all op_* 0, out_valid 0, out_h 0, cfg_err 0, busy 0.
  - Reset mid-step aborts the step; any later res_valid is ignored.
- States: IDLE -> ISSUE -> WAIT -> (ISSUE for next op | OUTPUT) -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch x, clear h if in_first, set op index k=0, go to ISSUE.
  - cfg writes are accepted only in IDLE.
- ISSUE: op_valid=1 for exactly one cycle with the operands of op k; next state WAIT. Operand registers hold their values until the next ISSUE.
- WAIT:
  - On res_valid, store the result into op k's destination.
  - If k<4: k+1, go to ISSUE. Otherwise write res_data to h, go to OUTPUT.
  - res_valid in any other state is ignored.
- Micro-op list (a, wa, b, wb, bias, act -> dest):
  - k0: x, Wz, h, Uz, bz, sigmoid -> Zt
  - k1: x, Wr, h, Ur, br, sigmoid -> Rt
  - k2: Rt, h, 0, 0, bh, none -> ht0
  - k3: x, Wh, ht0, Uh, 0, tanh -> Ht
  - k4: om, h, Zt, Ht, 0, none -> new h, where om = ONE - Zt computed internally, DATA_WIDTH wrap-around (no saturation).
- OUTPUT:
  - out_valid=1, out_h=h; hold both stable until out_ready, then return to IDLE.
  - in_ready=0 while in OUTPUT, so there is no overlap between steps.
- Minimum step latency with unit latency L: 1 (accept) + 5*(1+L) + 1 cycles to out_valid.
- Simultaneous cfg_we and in_valid in IDLE: the config write takes effect before the step's first ISSUE.
- cfg_err pulses the cycle after:
  - any cfg_we outside IDLE (write dropped, registers unchanged), or
  - any cfg_we with cfg_addr >= 9 (write dropped).
- in_first=0 on the first sample after reset uses h=0 (the reset value).

Test Plan:
- Reset then idle -> in_ready=1, busy=0, out_h=0, op_valid never asserted over 20 cycles.
- Config: write Wz=0x20, Uz=0x10, bz=0x08 in IDLE; send in_x=0x10, in_first=1 -> first op_valid has op_a=0x10, op_wa=0x20, op_b=0x00, op_wb=0x10, op_bias=0x08, op_act=1.
- Bench model unit at L=3 with fixed results Zt=0x10, Rt=0x18, ht0=0x04, Ht=0x0C -> k4 issues op_a=0x10 (0x20-0x10), op_b=0x10, op_wb=0x0C; out_valid exactly 22 cycles after acceptance; out_h equals the model's k4 result.
- Hold out_ready=0 for 5 cycles at OUTPUT -> out_h stable, in_ready=0, a new in_valid is not accepted; accepted on the cycle after out_ready.
- Second sample with in_first=0 -> k0 op_b equals the previous out_h; with in_first=1 -> op_b=0x00.
- cfg_we during WAIT, and cfg_addr=12 in IDLE -> cfg_err pulse each time, registers unchanged. Assert rst in WAIT, then a stray res_valid -> no state change, outputs at reset values.
